// File: rtl/exec_xfer_ctrl_if.sv
// Bus bundle between exec_xfer_ctrl and its FIFO buffer / exec engine.
// master: the transfer controller. slave: the FIFO buffer and exec side.
// FIFO side : f_abort, c_cmd*, cmdByteIn, e_execDone, c_rsp*, rspByteOut
// Exec side : x_cmd*, x_rsp*, x_sizeErr
interface exec_xfer_ctrl_if #(
  parameter int unsigned BUF_SIZE = 4096
);
  localparam int unsigned AW = $clog2(BUF_SIZE);
  localparam int unsigned LW = AW + 1;

  logic          f_abort;
  logic [31:0]   c_cmdSize;
  logic          c_cmdSend;
  logic [7:0]    cmdByteIn;
  logic [AW-1:0] c_cmdInAddr;
  logic          c_cmdDone;
  logic          e_execDone;
  logic [31:0]   c_rspSize;
  logic          c_rspSend;
  logic [AW-1:0] c_rspInAddr;
  logic [7:0]    rspByteOut;
  logic          c_rspDone;
  logic          x_cmdWren_n;
  logic [AW-1:0] x_cmdAddr;
  logic [7:0]    x_cmdByte;
  logic          x_cmdValid;
  logic [LW-1:0] x_cmdLen;
  logic          x_rspReady;
  logic [31:0]   x_rspSize;
  logic [AW-1:0] x_rspAddr;
  logic [7:0]    x_rspByte;
  logic          x_sizeErr;

  modport master (
    input  f_abort, c_cmdSize, c_cmdSend, cmdByteIn, x_rspReady, x_rspSize, x_rspByte,
    output c_cmdInAddr, c_cmdDone, e_execDone, c_rspSize, c_rspSend, c_rspInAddr,
           rspByteOut, c_rspDone, x_cmdWren_n, x_cmdAddr, x_cmdByte, x_cmdValid,
           x_cmdLen, x_rspAddr, x_sizeErr
  );

  modport slave (
    output f_abort, c_cmdSize, c_cmdSend, cmdByteIn, x_rspReady, x_rspSize, x_rspByte,
    input  c_cmdInAddr, c_cmdDone, e_execDone, c_rspSize, c_rspSend, c_rspInAddr,
           rspByteOut, c_rspDone, x_cmdWren_n, x_cmdAddr, x_cmdByte, x_cmdValid,
           x_cmdLen, x_rspAddr, x_sizeErr
  );
endinterface

// File: rtl/exec_xfer_ctrl.sv
// Moves a command from the FIFO buffer into exec command memory, waits for
// the exec engine, then moves the response from exec memory back to the FIFO.
// Ports: clock, reset_n (async, active-low), bus (exec_xfer_ctrl_if.master).
module exec_xfer_ctrl #(
  parameter int unsigned BUF_SIZE = 4096
) (
  input  logic             clock,
  input  logic             reset_n,
  exec_xfer_ctrl_if.master bus
);
  localparam int unsigned AW      = $clog2(BUF_SIZE);
  localparam int unsigned LW      = AW + 1;
  localparam logic [31:0] BUF_MAX = 32'(BUF_SIZE);

  typedef enum logic [3:0] {
    IDLE, CMD_RD, CMD_DONE, EXEC_WAIT, RSP_NOTIFY,
    RSP_SETTLE1, RSP_SETTLE2, RSP_XFER, RSP_DONE
  } state_e;

  state_e        state_q;
  logic [LW-1:0] cnt_q, len_q, cmd_len_q;
  logic [AW-1:0] cmd_in_addr_q, cmd_addr_q, rsp_addr_q, rsp_in_addr_q;
  logic [31:0]   rsp_size_q;
  logic          cmd_wr_q, rsp_wr_q, cmd_done_q, exec_done_q, rsp_done_q, size_err_q;

  // Clamped sizes, size-error detection and counter increment.
  logic [LW-1:0] n_d, m_d, cnt_inc_d;
  logic          cmd_bad_d, rsp_bad_d;
  always_comb begin
    n_d       = (bus.c_cmdSize > BUF_MAX) ? LW'(BUF_SIZE) : LW'(bus.c_cmdSize);
    m_d       = (bus.x_rspSize > BUF_MAX) ? LW'(BUF_SIZE) : LW'(bus.x_rspSize);
    cmd_bad_d = (bus.c_cmdSize == 32'd0) || (bus.c_cmdSize > BUF_MAX);
    rsp_bad_d = (bus.x_rspSize == 32'd0) || (bus.x_rspSize > BUF_MAX);
    cnt_inc_d = cnt_q + LW'(1);
  end

  // Transfer FSM with its registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      len_q         <= '0;
      cmd_len_q     <= '0;
      cmd_in_addr_q <= '0;
      cmd_addr_q    <= '0;
      rsp_addr_q    <= '0;
      rsp_in_addr_q <= '0;
      rsp_size_q    <= '0;
      cmd_wr_q      <= 1'b0;
      rsp_wr_q      <= 1'b0;
      cmd_done_q    <= 1'b0;
      exec_done_q   <= 1'b0;
      rsp_done_q    <= 1'b0;
      size_err_q    <= 1'b0;
    end else begin
      cmd_done_q  <= 1'b0;
      exec_done_q <= 1'b0;
      rsp_done_q  <= 1'b0;
      if (bus.f_abort) begin
        state_q       <= IDLE;
        cnt_q         <= '0;
        cmd_in_addr_q <= '0;
        cmd_addr_q    <= '0;
        rsp_addr_q    <= '0;
        rsp_in_addr_q <= '0;
        cmd_wr_q      <= 1'b0;
        rsp_wr_q      <= 1'b0;
      end else begin
        case (state_q)
          IDLE: if (bus.c_cmdSend) begin
            len_q         <= n_d;
            cnt_q         <= '0;
            cmd_in_addr_q <= '0;
            size_err_q    <= cmd_bad_d;
            if (n_d == '0) begin
              state_q    <= CMD_DONE;
              cmd_done_q <= 1'b1;
              cmd_len_q  <= '0;
            end else begin
              state_q <= CMD_RD;
            end
          end
          // Reads run one cycle ahead of writes; cnt_q == len_q is the drain cycle.
          CMD_RD: begin
            cnt_q         <= cnt_inc_d;
            cmd_wr_q      <= (cnt_q < len_q);
            cmd_addr_q    <= (cnt_q < len_q) ? cnt_q[AW-1:0] : '0;
            cmd_in_addr_q <= (cnt_inc_d < len_q) ? cnt_inc_d[AW-1:0] : '0;
            if (cnt_q == len_q) begin
              state_q    <= CMD_DONE;
              cmd_done_q <= 1'b1;
              cmd_len_q  <= len_q;
            end
          end
          CMD_DONE: state_q <= EXEC_WAIT;
          EXEC_WAIT: if (bus.x_rspReady) begin
            rsp_size_q  <= 32'(m_d);
            len_q       <= m_d;
            size_err_q  <= size_err_q | rsp_bad_d;
            exec_done_q <= 1'b1;
            state_q     <= RSP_NOTIFY;
          end
          RSP_NOTIFY:  state_q <= RSP_SETTLE1;
          RSP_SETTLE1: state_q <= RSP_SETTLE2;
          // Exec read of byte 0 is issued here (address 0), so XFER starts with data.
          RSP_SETTLE2: begin
            if (len_q == '0) begin
              state_q    <= RSP_DONE;
              rsp_done_q <= 1'b1;
            end else begin
              state_q       <= RSP_XFER;
              cnt_q         <= '0;
              rsp_wr_q      <= 1'b1;
              rsp_in_addr_q <= '0;
              rsp_addr_q    <= AW'(1);
            end
          end
          RSP_XFER: begin
            if (cnt_inc_d == len_q) begin
              state_q       <= RSP_DONE;
              rsp_done_q    <= 1'b1;
              rsp_wr_q      <= 1'b0;
              rsp_in_addr_q <= '0;
              rsp_addr_q    <= '0;
            end else begin
              cnt_q         <= cnt_inc_d;
              rsp_in_addr_q <= rsp_in_addr_q + AW'(1);
              rsp_addr_q    <= rsp_addr_q + AW'(1);
            end
          end
          RSP_DONE: state_q <= IDLE;
          default:  state_q <= IDLE;
        endcase
      end
    end
  end

  // Strobes and pulses are gated by f_abort so an abort silences them at once.
  assign bus.c_cmdInAddr = cmd_in_addr_q;
  assign bus.c_cmdDone   = cmd_done_q & ~bus.f_abort;
  assign bus.x_cmdValid  = cmd_done_q & ~bus.f_abort;
  assign bus.x_cmdLen    = cmd_len_q;
  assign bus.x_cmdWren_n = ~(cmd_wr_q & ~bus.f_abort);
  assign bus.x_cmdAddr   = cmd_addr_q;
  assign bus.x_cmdByte   = cmd_wr_q ? bus.cmdByteIn : 8'h00;
  assign bus.e_execDone  = exec_done_q & ~bus.f_abort;
  assign bus.c_rspSize   = rsp_size_q;
  assign bus.c_rspSend   = ~(rsp_wr_q & ~bus.f_abort);
  assign bus.c_rspInAddr = rsp_in_addr_q;
  assign bus.rspByteOut  = rsp_wr_q ? bus.x_rspByte : 8'h00;
  assign bus.c_rspDone   = rsp_done_q & ~bus.f_abort;
  assign bus.x_rspAddr   = rsp_addr_q;
  assign bus.x_sizeErr   = size_err_q;
endmodule

// File: doc/exec_xfer_ctrl.md
EXEC_XFER_CTRL -- requirements
Module: exec_xfer_ctrl

Interface
REQ-001 SHALL have parameter BUF_SIZE, default 4096, maximum transfer length in bytes; address width is clog2(BUF_SIZE).
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
- clock, in, 1, rising-edge clock.
- reset_n, in, 1, asynchronous active-low reset.
- f_abort, in, 1, front-side abort of the FIFO buffer.
- c_cmdSize, in, 32, command size from the FIFO buffer.
- c_cmdSend, in, 1, one-cycle pulse: the command is ready to be pulled.
- cmdByteIn, in, 8, FIFO read data; 1-cycle latency from c_cmdInAddr.
- c_cmdInAddr, out, 12, FIFO read address.
- c_cmdDone, out, 1, one-cycle pulse: command pull complete.
- e_execDone, out, 1, one-cycle pulse to the FIFO: response available.
- c_rspSize, out, 32, clamped response size.
- c_rspSend, out, 1, active-low FIFO write strobe.
- c_rspInAddr, out, 12, FIFO write address.
- rspByteOut, out, 8, FIFO write data.
- c_rspDone, out, 1, one-cycle pulse: response push complete.
- x_cmdWren_n, out, 1, active-low exec command-memory write strobe.
- x_cmdAddr, out, 12, exec command-memory write address.
- x_cmdByte, out, 8, exec command-memory write data.
- x_cmdValid, out, 1, one-cycle pulse: command present in exec memory.
- x_cmdLen, out, 13, clamped command length.
- x_rspReady, in, 1, exec response ready.
- x_rspSize, in, 32, response size; sampled with x_rspReady.
- x_rspAddr, out, 12, exec response-memory read address.
- x_rspByte, in, 8, exec read data; 1-cycle latency from x_rspAddr.
- x_sizeErr, out, 1, sticky flag: a size was 0 or larger than BUF_SIZE.
REQ-003 SHALL be clocked by clock with reset reset_n, asynchronous, active-low.

Function
REQ-004 SHALL implement these states: IDLE, CMD_RD, CMD_DONE, EXEC_WAIT, RSP_NOTIFY, RSP_SETTLE1, RSP_SETTLE2, RSP_XFER, RSP_DONE.
REQ-005 SHALL, in IDLE on c_cmdSend (cycle S), latch N = min(c_cmdSize, BUF_SIZE) and clear x_sizeErr; next state is CMD_RD, or CMD_DONE if N=0.
REQ-006 SHALL, in CMD_RD, drive c_cmdInAddr = k in cycle S+1+k for k = 0..N-1.
REQ-007 SHALL, in cycle S+2+k, drive x_cmdWren_n=0, x_cmdAddr=k, and x_cmdByte=cmdByteIn.
- The last write occurs at S+1+N.
REQ-008 SHALL enter CMD_DONE at S+2+N, pulse c_cmdDone and x_cmdValid there for one cycle with x_cmdLen=N, then go to EXEC_WAIT.
REQ-009 SHALL set x_sizeErr if c_cmdSize=0 or c_cmdSize>BUF_SIZE; the same rule applies to x_rspSize.
REQ-010 SHALL, in EXEC_WAIT on x_rspReady, register c_rspSize = min(x_rspSize, BUF_SIZE) as M and go to RSP_NOTIFY.
REQ-011 SHALL pulse e_execDone in RSP_NOTIFY (cycle T); c_rspSize SHALL be stable from T until the next IDLE.
REQ-012 SHALL keep c_rspSend=1 in RSP_NOTIFY, RSP_SETTLE1 and RSP_SETTLE2, and drive x_rspAddr=0 in RSP_SETTLE2 (T+2).
REQ-013 SHALL, in RSP_XFER at cycle T+3+k for k = 0..M-1:
- drive c_rspSend=0, c_rspInAddr=k, rspByteOut=x_rspByte;
- drive x_rspAddr=k+1 (prefetch).
REQ-014 SHALL pulse c_rspDone in RSP_DONE at T+3+M, then return to IDLE.
- If M=0, go from RSP_SETTLE2 directly to RSP_DONE with no write strobes.
REQ-015 SHALL use a 13-bit byte counter so that N or M = 4096 completes; address outputs are the low 12 bits.
REQ-016 SHALL ignore c_cmdSend outside IDLE and ignore x_rspReady outside EXEC_WAIT.
REQ-017 SHALL, on f_abort in any state, go to IDLE on the next edge.
- All strobes go inactive immediately (combinationally gated).
- No done or valid pulses are issued.
- If f_abort and c_cmdSend are high in the same cycle, abort wins.
REQ-018 SHALL hold c_cmdInAddr, x_rspAddr and c_rspInAddr at 0 when not transferring.

Reset
REQ-019 SHALL, while reset_n=0, force the following regardless of clock:
- state = IDLE;
- c_cmdDone, c_rspDone, e_execDone, x_cmdValid, x_sizeErr = 0;
- c_rspSend, x_cmdWren_n = 1;
- all addresses, c_rspSize, x_cmdLen, rspByteOut, x_cmdByte = 0.
REQ-020 SHALL leave IDLE after reset only on c_cmdSend.

Verification
REQ-021 Command pull: c_cmdSize=10, c_cmdSend at S.
- c_cmdInAddr 0..9 at S+1..S+10.
- 10 exec writes at S+2..S+11 matching FIFO bytes.
- c_cmdDone and x_cmdValid at S+12, x_cmdLen=10.
REQ-022 Response push: x_rspSize=14 with x_rspReady.
- e_execDone at T.
- c_rspSend low T+3..T+16, c_rspInAddr 0..13, data equals exec memory.
- c_rspDone at T+17.
REQ-023 Oversize: c_cmdSize=5000.
- x_cmdLen=4096, x_sizeErr=1.
- The last c_cmdInAddr is 0xFFF, and c_cmdDone is issued.
REQ-024 Abort: f_abort mid-CMD_RD at byte 3.
- IDLE next cycle; no c_cmdDone.
- A following c_cmdSend restarts from address 0.
REQ-025 Zero size: x_rspSize=0.
- e_execDone, then c_rspDone at T+3, with no c_rspSend low; x_sizeErr=1.
REQ-026 Async reset asserted during RSP_XFER: c_rspSend=1 and state=IDLE before the next clock edge.
